// File: rtl/tm1638_keyscan.sv
// TM1638 key scanner: periodic or requested 32-bit key read over the shared STB/CLK/DIO bus.
// Optional build macro TM1638_KEY_DEBOUNCE_EN: accept a scan only when it repeats the previous raw word.
module tm1638_keyscan #(
  parameter int unsigned SCAN_DIV = 10000,
  parameter logic [7:0]  READ_CMD = 8'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic        scan_req,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        tm1638_clk,
  output logic        tm1638_stb,
  output logic        tm1638_dio_o,
  output logic        tm1638_dio_oe,
  input  logic        tm1638_dio_i,
  output logic [31:0] keys,
  output logic        keys_valid
);

  localparam int unsigned   CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    STB_LO = 3'd2,
    CMD    = 3'd3,
    WAIT   = 3'd4,
    READ   = 3'd5,
    STB_HI = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          pend_q, pend_d;
  logic [5:0]    tick_q, tick_d;      // tick_q[0] = half-bit phase, tick_q[5:1] = bit index
  logic [31:0]   shift_q, shift_d;
  logic          clk_q, clk_d;
  logic          stb_q, stb_d;
  logic          dio_q, dio_d;
  logic          oe_q, oe_d;
  logic          req_q, req_d;
  logic [31:0]   keys_q, keys_d;
  logic          valid_q, valid_d;
`ifdef TM1638_KEY_DEBOUNCE_EN
  logic [31:0]   raw_q, raw_d;
`endif

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    pend_d     = pend_q | scan_req;
    tick_d     = tick_q;
    shift_d    = shift_q;
    clk_d      = clk_q;
    stb_d      = stb_q;
    dio_d      = dio_q;
    oe_d       = oe_q;
    req_d      = req_q;
    keys_d     = keys_q;
    valid_d    = 1'b0;
`ifdef TM1638_KEY_DEBOUNCE_EN
    raw_d      = raw_q;
`endif
    case (state_q)
      IDLE: begin
        if (clken) begin
          if ((scan_cnt_q == {CW{1'b0}}) || pend_q) begin
            scan_cnt_d = RELOAD;
            pend_d     = 1'b0;
            req_d      = 1'b1;
            state_d    = REQ;
          end else begin
            scan_cnt_d = scan_cnt_q - CW'(1);
          end
        end else begin
          scan_cnt_d = scan_cnt_q;
        end
      end
      REQ: begin
        if (clken && bus_gnt) begin
          state_d = STB_LO;
        end else begin
          state_d = REQ;
        end
      end
      STB_LO: begin
        if (clken) begin
          stb_d   = 1'b0;
          oe_d    = 1'b1;
          tick_d  = 6'd0;
          state_d = CMD;
        end else begin
          state_d = STB_LO;
        end
      end
      CMD: begin
        if (clken) begin
          if (!tick_q[0]) begin
            clk_d  = 1'b0;
            dio_d  = READ_CMD[tick_q[3:1]];
            tick_d = tick_q + 6'd1;
          end else if (tick_q == 6'd15) begin
            // Release DIO on the last rising edge so the bus is never driven in WAIT.
            clk_d   = 1'b1;
            oe_d    = 1'b0;
            dio_d   = 1'b1;
            tick_d  = 6'd0;
            state_d = WAIT;
          end else begin
            clk_d  = 1'b1;
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      WAIT: begin
        if (clken) begin
          if (tick_q == 6'd1) begin
            tick_d  = 6'd0;
            state_d = READ;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      READ: begin
        if (clken) begin
          if (!tick_q[0]) begin
            clk_d  = 1'b0;
            tick_d = tick_q + 6'd1;
          end else begin
            // Bits arrive first-to-last, so shifting in at the top leaves bit 0 = first bit.
            shift_d = {tm1638_dio_i, shift_q[31:1]};
            clk_d   = 1'b1;
            if (tick_q == 6'd63) begin
              tick_d  = 6'd0;
              state_d = STB_HI;
            end else begin
              tick_d = tick_q + 6'd1;
            end
          end
        end else begin
          tick_d = tick_q;
        end
      end
      STB_HI: begin
        if (clken) begin
          stb_d   = 1'b1;
          clk_d   = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
`ifdef TM1638_KEY_DEBOUNCE_EN
          raw_d = shift_q;
          if (shift_q == raw_q) begin
            keys_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            keys_d  = keys_q;
            valid_d = 1'b0;
          end
`else
          keys_d  = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          state_d = STB_HI;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b1;
        clk_d   = 1'b1;
        dio_d   = 1'b1;
        oe_d    = 1'b0;
        req_d   = 1'b0;
        tick_d  = 6'd0;
      end
    endcase
  end

  // State and output registers; reset overrides clken, scan_req and bus_gnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_cnt_q <= RELOAD;
      pend_q     <= 1'b0;
      tick_q     <= 6'd0;
      shift_q    <= 32'd0;
      clk_q      <= 1'b1;
      stb_q      <= 1'b1;
      dio_q      <= 1'b1;
      oe_q       <= 1'b0;
      req_q      <= 1'b0;
      keys_q     <= 32'd0;
      valid_q    <= 1'b0;
`ifdef TM1638_KEY_DEBOUNCE_EN
      raw_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      shift_q    <= shift_d;
      clk_q      <= clk_d;
      stb_q      <= stb_d;
      dio_q      <= dio_d;
      oe_q       <= oe_d;
      req_q      <= req_d;
      keys_q     <= keys_d;
      valid_q    <= valid_d;
`ifdef TM1638_KEY_DEBOUNCE_EN
      raw_q      <= raw_d;
`endif
    end
  end

  assign bus_req       = req_q;
  assign tm1638_clk    = clk_q;
  assign tm1638_stb    = stb_q;
  assign tm1638_dio_o  = dio_q;
  assign tm1638_dio_oe = oe_q;
  assign keys          = keys_q;
  assign keys_valid    = valid_q;

endmodule

// File: doc/tm1638_keyscan.md
TM1638_KEYSCAN -- requirements
Module: tm1638_keyscan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10000, meaning clken ticks between automatic scans (10 ms at 1 MHz clken).
REQ-002 SHALL have parameter READ_CMD, default 8'h42, meaning the TM1638 read-key-data command byte.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clken  in  1  single-cycle tick; every state advance is gated by it; tick = one half serial-bit.
REQ-006 scan_req  in  1  one-cycle pulse requesting an immediate scan.
REQ-007 bus_req  out  1  high while the block needs or owns the shared TM1638 lines.
REQ-008 bus_gnt  in  1  high when the display writer has released the TM1638 lines.
REQ-009 tm1638_clk, tm1638_stb  out  1 each  serial clock and strobe; idle high.
REQ-010 tm1638_dio_o, tm1638_dio_oe  out  1 each  DIO drive value and drive enable.
REQ-011 tm1638_dio_i  in  1  DIO pin sampled value.
REQ-012 keys  out  32  last accepted scan word; bit 0 = first bit read.
REQ-013 keys_valid  out  1  one-cycle pulse when keys updates.

Function
REQ-014 States SHALL be IDLE, REQ, STB_LO, CMD, WAIT, READ, STB_HI.
REQ-015 Scan counter SHALL decrement on clken in IDLE; at zero, or on a pending scan_req, it reloads SCAN_DIV-1 and the FSM enters REQ.
REQ-016 scan_req arriving while not in IDLE SHALL set one pending flag (further pulses merged), cleared on entering REQ.
REQ-017 REQ: bus_req=1; on clken with bus_gnt=1, go to STB_LO; bus_gnt SHALL NOT be sampled in any other state.
REQ-018 STB_LO: on one clken, tm1638_stb<=0, dio_oe<=1, go to CMD.
REQ-019 CMD: 8 bits LSB first, 2 ticks each: tick A clk<=0, dio_o<=READ_CMD[n]; tick B clk<=1.
REQ-020 WAIT: dio_oe<=0, dio_o<=1, hold clk high for 2 ticks (>=1 us turnaround).
REQ-021 READ: 32 bits, 2 ticks each: tick A clk<=0; tick B sample dio_i into shift bit n, then clk<=1.
REQ-022 STB_HI: on one clken, stb<=1, clk=1, bus_req<=0; update keys and pulse keys_valid in the same cycle; go to IDLE.
REQ-023 Latency grant-to-keys_valid SHALL be exactly 84 clken ticks (1+16+2+64+1).
REQ-024 bus_gnt falling mid-transaction SHALL be ignored; the transaction completes.
REQ-025 Bit and tick counters SHALL be 5/6 bits, no wrap beyond their terminal count.
REQ-026 dio_oe SHALL be 0 in every state except STB_LO and CMD.

Reset
REQ-027 On reset, at any state including mid-transfer: FSM=IDLE, stb=1, clk=1, dio_o=1, dio_oe=0, bus_req=0, keys=0, keys_valid=0, pending=0, scan counter=SCAN_DIV-1.
REQ-028 Reset SHALL take priority over clken, scan_req and bus_gnt in the same cycle.

Configuration
REQ-029 Macro TM1638_KEY_DEBOUNCE_EN defined: keys updates (and keys_valid pulses) only when the new scan word equals the previous raw scan word; otherwise raw word stored, keys unchanged.
REQ-030 Macro undefined: every completed scan updates keys and pulses keys_valid.

Verification
REQ-031 Reset, clken every 4 clks, bus_gnt=1, TM1638 model returns 32'h00000011 -> after 84 ticks keys=32'h00000011, one keys_valid pulse, stb high.
REQ-032 scan_req with bus_gnt=0 for 50 ticks -> bus_req=1, stb/clk remain 1, dio_oe=0 until grant; then scan completes 84 ticks after grant.
REQ-033 Monitor CMD phase -> DIO bits 0,1,0,0,0,0,1,0 sampled at clk rising edges (8'h42 LSB first), dio_oe=0 during WAIT and READ.
REQ-034 reset asserted at READ bit 10 -> next cycle stb=1, dio_oe=0, bus_req=0, keys=0; no keys_valid.
REQ-035 DEBOUNCE_EN defined, scans return A5A5A5A5 then 5A5A5A5A then 5A5A5A5A -> keys_valid only after third scan, keys=32'h5A5A5A5A; undefined -> three pulses.
REQ-036 Three scan_req pulses during a scan -> exactly one further scan follows.
